// File: rtl/nf_mem_pkg.sv
// Shared definitions for the nanoFOX memory/writeback path: load size codes,
// writeback FSM states and the load metadata captured while a response is pending.
package nf_mem_pkg;

    localparam logic [1:0] NF_LD_B = 2'd0;
    localparam logic [1:0] NF_LD_H = 2'd1;
    localparam logic [1:0] NF_LD_W = 2'd2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } nf_wb_state_e;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_we;
        logic [1:0] size;
        logic       sign_ext;
        logic [1:0] addr_lo;
    } nf_ld_meta_t;

    // x0 is hardwired to zero, so a write to it is never issued.
    function automatic logic rd_writes(input logic we, input logic [4:0] rd);
        return we && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/nf_wb_stage_if.sv
// Memory-stage / data-memory inputs and register-file / forwarding outputs
// of the writeback stage, bundled for port connection.
interface nf_wb_stage_if;

    logic        mem_vld;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [1:0]  mem_size;
    logic        mem_sign_ext;
    logic [1:0]  mem_addr_lo;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        stall_req;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        we3;
    logic        fwd_vld;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        ld_err;

    modport slave (
        input  mem_vld, mem_rd_addr, mem_rd_we, mem_result, mem_is_load,
               mem_size, mem_sign_ext, mem_addr_lo, dm_rvalid, dm_rdata,
        output stall_req, wa3, wd3, we3, fwd_vld, fwd_addr, fwd_data, ld_err
    );

    modport master (
        output mem_vld, mem_rd_addr, mem_rd_we, mem_result, mem_is_load,
               mem_size, mem_sign_ext, mem_addr_lo, dm_rvalid, dm_rdata,
        input  stall_req, wa3, wd3, we3, fwd_vld, fwd_addr, fwd_data, ld_err
    );

endinterface

// File: rtl/nf_ld_align.sv
// Load data alignment: picks the addressed byte/half lane out of the read word
// and sign- or zero-extends it to 32 bits. Reserved size 3 behaves as a word.
module nf_ld_align
    import nf_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Halves are assumed aligned, so only addr_lo[1] selects the lane.
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o    = rdata_i;
        case (size_i)
            NF_LD_B: data_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
            NF_LD_H: data_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
            NF_LD_W: data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/nf_wb_stage.sv
// nanoFOX writeback stage: drives the register-file write port and forwarding bus,
// stalling upstream while a data-memory load response is outstanding.
//
//  state      | meaning
//  -----------+---------------------------------------------------------------
//  ST_IDLE    | accept memory-stage results; zero-wait loads complete here
//  ST_WAIT_LD | load accepted without data; hold stall until dm_rvalid/timeout
module nf_wb_stage
    import nf_mem_pkg::*;
#(
    parameter int LD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    nf_wb_stage_if.slave    bus
);

    localparam int TW = (LD_TIMEOUT > 2) ? $clog2(LD_TIMEOUT) : 1;

    nf_wb_state_e   state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    nf_ld_meta_t    meta_q, meta_d;
    logic           we3_q, we3_d;
    logic [4:0]     wa3_q, wa3_d;
    logic [31:0]    wd3_q, wd3_d;
    logic           stall_req;
    logic           ld_err;
    logic [1:0]     al_size;
    logic           al_sign;
    logic [1:0]     al_addr_lo;
    logic [31:0]    al_data;

    // In IDLE a zero-wait load aligns with the live metadata; in WAIT_LD with the captured copy.
    assign al_size    = (state_q == ST_WAIT_LD) ? meta_q.size     : bus.mem_size;
    assign al_sign    = (state_q == ST_WAIT_LD) ? meta_q.sign_ext : bus.mem_sign_ext;
    assign al_addr_lo = (state_q == ST_WAIT_LD) ? meta_q.addr_lo  : bus.mem_addr_lo;

    nf_ld_align u_ld_align (
        .rdata_i    (bus.dm_rdata),
        .size_i     (al_size),
        .sign_ext_i (al_sign),
        .addr_lo_i  (al_addr_lo),
        .data_o     (al_data)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        meta_d    = meta_q;
        we3_d     = 1'b0;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        stall_req = 1'b0;
        ld_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_vld) begin
                    if (!bus.mem_is_load) begin
                        we3_d = rd_writes(bus.mem_rd_we, bus.mem_rd_addr);
                        wa3_d = bus.mem_rd_addr;
                        wd3_d = bus.mem_result;
                    end else if (bus.dm_rvalid) begin
                        we3_d = rd_writes(bus.mem_rd_we, bus.mem_rd_addr);
                        wa3_d = bus.mem_rd_addr;
                        wd3_d = al_data;
                    end else begin
                        meta_d    = '{rd_addr: bus.mem_rd_addr, rd_we: bus.mem_rd_we,
                                      size: bus.mem_size, sign_ext: bus.mem_sign_ext,
                                      addr_lo: bus.mem_addr_lo};
                        timer_d   = '0;
                        state_d   = ST_WAIT_LD;
                        stall_req = 1'b1;
                    end
                end
            end
            ST_WAIT_LD: begin
                if (bus.dm_rvalid) begin
                    we3_d   = rd_writes(meta_q.rd_we, meta_q.rd_addr);
                    wa3_d   = meta_q.rd_addr;
                    wd3_d   = al_data;
                    state_d = ST_IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (timer_q == TW'(LD_TIMEOUT - 1)) begin
                        ld_err  = 1'b1;
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            meta_q  <= '0;
            we3_q   <= 1'b0;
            wa3_q   <= 5'd0;
            wd3_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            meta_q  <= meta_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign bus.stall_req = stall_req;
    assign bus.ld_err    = ld_err;
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.fwd_vld   = we3_q;
    assign bus.fwd_addr  = wa3_q;
    assign bus.fwd_data  = wd3_q;

endmodule

// File: tb/tb_nf_wb_stage.sv
// Self-checking bench for nf_wb_stage: directed scenarios plus randomized
// ALU/load traffic against a behavioural alignment and latency model.
module tb_nf_wb_stage;

    localparam int LDT = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nf_wb_stage_if bus_if ();

    nf_wb_stage #(.LD_TIMEOUT(LDT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Reference alignment from the lane rules, using shifts and masks.
    function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] lo);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (int'(lo) * 8)) & 32'h0000_00FF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.mem_vld   = 1'b0;
        bus_if.dm_rvalid = 1'b0;
        bus_if.dm_rdata  = $urandom;
    endtask

    task automatic drive_op(input logic ld, input logic [4:0] rd, input logic we,
                            input logic [31:0] res, input logic [1:0] sz,
                            input logic sg, input logic [1:0] lo);
        bus_if.mem_vld      = 1'b1;
        bus_if.mem_is_load  = ld;
        bus_if.mem_rd_addr  = rd;
        bus_if.mem_rd_we    = we;
        bus_if.mem_result   = res;
        bus_if.mem_size     = sz;
        bus_if.mem_sign_ext = sg;
        bus_if.mem_addr_lo  = lo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        drive_op(1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 1'b0, 2'd0);
        bus_if.mem_vld = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3 got %b exp 0", bus_if.we3); end
        n_tests++; if (bus_if.wa3 !== 5'd0) begin n_fail++; $display("FAIL reset_wa3 got %0d exp 0", bus_if.wa3); end
        n_tests++; if (bus_if.wd3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3 got %h exp 0", bus_if.wd3); end
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus_if.stall_req); end
        n_tests++; if (bus_if.ld_err !== 1'b0) begin n_fail++; $display("FAIL reset_ld_err got %b exp 0", bus_if.ld_err); end
        n_tests++; if (bus_if.fwd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_vld got %b exp 0", bus_if.fwd_vld); end
    endtask

    task automatic test_alu();
        drive_op(1'b0, 5'd5, 1'b1, 32'h1234_5678, 2'd2, 1'b0, 2'd0);
        #1;
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", bus_if.stall_req); end
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b1) begin n_fail++; $display("FAIL alu_we3 got %b exp 1", bus_if.we3); end
        n_tests++; if (bus_if.wa3 !== 5'd5) begin n_fail++; $display("FAIL alu_wa3 got %0d exp 5", bus_if.wa3); end
        n_tests++; if (bus_if.wd3 !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_wd3 got %h exp 12345678", bus_if.wd3); end
        n_tests++; if ({bus_if.fwd_vld, bus_if.fwd_addr, bus_if.fwd_data} !== {1'b1, 5'd5, 32'h1234_5678})
            begin n_fail++; $display("FAIL alu_fwd got %b/%0d/%h exp 1/5/12345678", bus_if.fwd_vld, bus_if.fwd_addr, bus_if.fwd_data); end
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall2 got %b exp 0", bus_if.stall_req); end
        cyc();
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle got %b exp 0", bus_if.we3); end
    endtask

    task automatic test_zero_wait_lb();
        logic [31:0] exp_d [2];
        logic [1:0]  los   [2];
        exp_d[0] = 32'hFFFF_FF80; los[0] = 2'd3;
        exp_d[1] = 32'h0000_007F; los[1] = 2'd1;
        for (int i = 0; i < 2; i++) begin
            drive_op(1'b1, 5'd9, 1'b1, 32'hDEAD_DEAD, 2'd0, 1'b1, los[i]);
            bus_if.dm_rvalid = 1'b1;
            bus_if.dm_rdata  = 32'h80FF_7F01;
            #1;
            n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL lb_stall[%0d] got %b exp 0", i, bus_if.stall_req); end
            cyc();
            idle_inputs();
            n_tests++; if (bus_if.we3 !== 1'b1 || bus_if.wd3 !== exp_d[i] || bus_if.wa3 !== 5'd9)
                begin n_fail++; $display("FAIL lb_write[%0d] got we=%b wa=%0d wd=%h exp we=1 wa=9 wd=%h", i, bus_if.we3, bus_if.wa3, bus_if.wd3, exp_d[i]); end
        end
        cyc();
    endtask

    task automatic test_lhu_3cycle();
        int stalls = 0;
        drive_op(1'b1, 5'd7, 1'b1, 32'h0, 2'd1, 1'b0, 2'd2);
        bus_if.dm_rvalid = 1'b0;
        #1;
        if (bus_if.stall_req === 1'b1) stalls++;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            drive_op(1'b0, 5'd3, 1'b0, 32'h0, 2'd0, 1'b1, 2'd1);  // scrambled; ignored while waiting
            bus_if.dm_rvalid = (k == 3);
            bus_if.dm_rdata  = (k == 3) ? 32'hBEEF_0000 : 32'h1111_2222;
            #1;
            if (bus_if.stall_req === 1'b1) stalls++;
            n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL lhu_early_we3[%0d] got %b exp 0", k, bus_if.we3); end
        end
        n_tests++; if (stalls !== 3) begin n_fail++; $display("FAIL lhu_stall_cycles got %0d exp 3", stalls); end
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b1 || bus_if.wa3 !== 5'd7 || bus_if.wd3 !== 32'h0000_BEEF)
            begin n_fail++; $display("FAIL lhu_write got we=%b wa=%0d wd=%h exp we=1 wa=7 wd=0000beef", bus_if.we3, bus_if.wa3, bus_if.wd3); end
        cyc();
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL lhu_one_cycle got %b exp 0", bus_if.we3); end
    endtask

    task automatic test_x0();
        drive_op(1'b0, 5'd0, 1'b1, 32'hAAAA_5555, 2'd2, 1'b0, 2'd0);
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL x0_alu_we3 got %b exp 0", bus_if.we3); end
        drive_op(1'b1, 5'd0, 1'b1, 32'h0, 2'd2, 1'b0, 2'd0);
        bus_if.dm_rvalid = 1'b0;
        #1;
        n_tests++; if (bus_if.stall_req !== 1'b1) begin n_fail++; $display("FAIL x0_ld_stall got %b exp 1", bus_if.stall_req); end
        cyc();
        bus_if.dm_rvalid = 1'b1;
        bus_if.dm_rdata  = 32'h1234_5678;
        #1;
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL x0_ld_release got %b exp 0", bus_if.stall_req); end
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL x0_ld_we3 got %b exp 0", bus_if.we3); end
        drive_op(1'b0, 5'd1, 1'b1, 32'h0000_0042, 2'd2, 1'b0, 2'd0);
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b1 || bus_if.wd3 !== 32'h42) begin n_fail++; $display("FAIL x0_followup got we=%b wd=%h exp we=1 wd=42", bus_if.we3, bus_if.wd3); end
    endtask

    task automatic test_timeout();
        int err_cnt = 0;
        int err_at  = -1;
        drive_op(1'b1, 5'd12, 1'b1, 32'h0, 2'd2, 1'b0, 2'd0);
        bus_if.dm_rvalid = 1'b0;
        #1;
        for (int k = 1; k <= LDT; k++) begin
            cyc();
            #1;
            if (bus_if.ld_err === 1'b1) begin err_cnt++; err_at = k; end
            n_tests++; if (bus_if.stall_req !== 1'b1) begin n_fail++; $display("FAIL to_stall[%0d] got %b exp 1", k, bus_if.stall_req); end
        end
        n_tests++; if (err_cnt !== 1 || err_at !== LDT) begin n_fail++; $display("FAIL to_ld_err got count=%0d at=%0d exp count=1 at=%0d", err_cnt, err_at, LDT); end
        cyc();
        idle_inputs();
        #1;
        n_tests++; if (bus_if.we3 !== 1'b0 || bus_if.ld_err !== 1'b0 || bus_if.stall_req !== 1'b0)
            begin n_fail++; $display("FAIL to_after got we=%b err=%b stall=%b exp 0/0/0", bus_if.we3, bus_if.ld_err, bus_if.stall_req); end
        drive_op(1'b0, 5'd4, 1'b1, 32'hCAFE_0001, 2'd2, 1'b0, 2'd0);
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b1 || bus_if.wd3 !== 32'hCAFE_0001) begin n_fail++; $display("FAIL to_idle_followup got we=%b wd=%h exp 1/cafe0001", bus_if.we3, bus_if.wd3); end
    endtask

    task automatic test_reset_midload();
        drive_op(1'b1, 5'd20, 1'b1, 32'h0, 2'd2, 1'b0, 2'd0);
        bus_if.dm_rvalid = 1'b0;
        cyc();
        cyc();
        bus_if.mem_vld = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus_if.dm_rvalid = 1'b1;
        bus_if.dm_rdata  = 32'h5A5A_5A5A;
        #1;
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b exp 0", bus_if.stall_req); end
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we3 got %b exp 0", bus_if.we3); end
        drive_op(1'b0, 5'd6, 1'b1, 32'h0BAD_F00D, 2'd2, 1'b0, 2'd0);
        #1;
        n_tests++; if (bus_if.stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got %b exp 0", bus_if.stall_req); end
        cyc();
        idle_inputs();
        n_tests++; if (bus_if.we3 !== 1'b1 || bus_if.wd3 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_mid_followup got we=%b wd=%h exp 1/0badf00d", bus_if.we3, bus_if.wd3); end
    endtask

    task automatic test_random();
        logic        ld, we, sg, exp_we;
        logic [4:0]  rd;
        logic [1:0]  sz, lo;
        logic [31:0] res, rdata, exp_d;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            ld    = 1'($urandom_range(0, 1));
            rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            we    = ($urandom_range(0, 5) != 0);
            sg    = 1'($urandom);
            sz    = 2'($urandom);
            lo    = 2'($urandom);
            res   = $urandom;
            rdata = $urandom;
            lat   = ld ? $urandom_range(0, LDT - 2) : 0;
            exp_we = we && (rd != 5'd0);
            exp_d  = ld ? ref_align(rdata, sz, sg, lo) : res;
            drive_op(ld, rd, we, res, sz, sg, lo);
            bus_if.dm_rvalid = (lat == 0) ? ($urandom_range(0, 1) == 1 || ld) : 1'b0;
            bus_if.dm_rdata  = (ld && lat == 0) ? rdata : $urandom;
            #1;
            n_tests++; if (bus_if.stall_req !== (ld && lat != 0)) begin n_fail++; $display("FAIL rnd_stall0[%0d] got %b exp %b", i, bus_if.stall_req, (ld && lat != 0)); end
            for (int k = 1; k <= lat; k++) begin
                cyc();
                drive_op(1'($urandom), 5'($urandom), 1'($urandom), $urandom, 2'($urandom), 1'($urandom), 2'($urandom));
                bus_if.dm_rvalid = (k == lat);
                bus_if.dm_rdata  = (k == lat) ? rdata : $urandom;
                #1;
                n_tests++; if (bus_if.stall_req !== (k != lat) || bus_if.ld_err !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_wait[%0d.%0d] got stall=%b err=%b exp stall=%b err=0", i, k, bus_if.stall_req, bus_if.ld_err, (k != lat)); end
            end
            cyc();
            idle_inputs();
            n_tests++; if (bus_if.we3 !== exp_we) begin n_fail++; $display("FAIL rnd_we3[%0d] got %b exp %b", i, bus_if.we3, exp_we); end
            if (exp_we) begin
                n_tests++; if (bus_if.wa3 !== rd || bus_if.wd3 !== exp_d || bus_if.fwd_addr !== rd || bus_if.fwd_data !== exp_d || bus_if.fwd_vld !== 1'b1)
                    begin n_fail++; $display("FAIL rnd_data[%0d] got wa=%0d wd=%h fwd=%b/%0d/%h exp wa=%0d wd=%h", i, bus_if.wa3, bus_if.wd3, bus_if.fwd_vld, bus_if.fwd_addr, bus_if.fwd_data, rd, exp_d); end
            end
            if ($urandom_range(0, 2) == 0) begin
                bus_if.dm_rvalid = 1'b1;  // stray response with nothing accepted
                cyc();
                idle_inputs();
                n_tests++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL rnd_stray[%0d] got %b exp 0", i, bus_if.we3); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_alu();
        test_zero_wait_lb();
        test_lhu_3cycle();
        test_x0();
        test_timeout();
        test_reset_midload();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
